morse_compose: RTL and testbench

- Morse keyer front end: samples a single key line, times each press against a slow tick, and classifies each press as short or long.
- Packs up to 5 symbols into the team's 10-bit morse word. Each 2-bit pair is {present, long}, left-justified, unused pairs 00.
- Emits the word with a one-cycle valid strobe when the character ends.
- Inverse of the 10-bit morse decomposer: feeding an emitted word to the decomposer reproduces the keyed symbol sequence.

---
 rtl/morse_compose_if.sv | 11 +
 rtl/morse_compose.sv | 112 +++++++++++
 tb/tb_morse_compose.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/morse_compose_if.sv
// Key/tick inputs and composed-word outputs of the morse keyer front end.
interface morse_compose_if;
  logic       tick;
  logic       key;
  logic [9:0] morse;
  logic       valid;
  logic       busy;

  modport master (output tick, output key, input morse, input valid, input busy);
  modport slave  (input tick, input key, output morse, output valid, output busy);
endinterface

// File: rtl/morse_compose.sv
// Morse keyer: times key presses against a slow tick and packs up to five
// {present, long} symbol pairs, left-justified, into a 10-bit word.
module morse_compose #(
  parameter int unsigned LONG_TICKS = 3,
  parameter int unsigned GAP_TICKS  = 5,
  parameter int unsigned CW         = 8
) (
  input logic           clk,
  input logic           reset,
  morse_compose_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StPress, StGap, StEmit} state_e;

  localparam logic [CW-1:0] CntMax  = {CW{1'b1}};
  localparam logic [CW-1:0] LongThr = CW'(LONG_TICKS);
  localparam logic [CW-1:0] GapLast = CW'(GAP_TICKS - 1);

  state_e        state_q, state_d;
  logic          key_meta_q, key_s_q;
  logic [9:0]    word_q, word_d, morse_q;
  logic [2:0]    nsym_q, nsym_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, emit, busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_meta_q <= 1'b0;
      key_s_q    <= 1'b0;
    end else begin
      key_meta_q <= bus.key;
      key_s_q    <= key_meta_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    nsym_d  = nsym_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (key_s_q) begin
          state_d = StPress;
          cnt_d   = '0;
        end
      end
      StPress: begin
        if (key_s_q) begin
          if (bus.tick && cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        end else if (cnt_q == '0) begin
          // Press shorter than one tick is a glitch: no symbol recorded.
          state_d = (nsym_q != 3'd0) ? StGap : StIdle;
        end else begin
          for (int i = 0; i < 5; i++) begin
            if (nsym_q == 3'(i)) word_d[9-2*i -: 2] = {1'b1, cnt_q >= LongThr};
          end
          nsym_d  = nsym_q + 3'd1;
          cnt_d   = '0;
          state_d = (nsym_q == 3'd4) ? StEmit : StGap;
        end
      end
      StGap: begin
        if (key_s_q) begin
          state_d = StPress;
          cnt_d   = '0;
        end else if (bus.tick) begin
          if (cnt_q == GapLast) state_d = StEmit;
          else                  cnt_d   = cnt_q + 1'b1;
        end
      end
      StEmit: begin
        word_d  = '0;
        nsym_d  = '0;
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    emit = (state_q == StEmit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q  <= '0;
      nsym_q  <= '0;
      cnt_q   <= '0;
      morse_q <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      nsym_q  <= nsym_d;
      cnt_q   <= cnt_d;
      valid_q <= emit;
      if (emit) morse_q <= word_q;
    end
  end

  assign bus.morse = morse_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy;

endmodule

// File: tb/tb_morse_compose.sv
// Directed bench for morse_compose with hand-computed expected words.
module tb_morse_compose;
  localparam int unsigned LongTicks = 3;
  localparam int unsigned GapTicks  = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   vpulses = 0;

  morse_compose_if bus ();

  morse_compose #(
    .LONG_TICKS(LongTicks),
    .GAP_TICKS (GapTicks),
    .CW        (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.valid === 1'b1) vpulses <= vpulses + 1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    @(negedge clk);
  endtask

  // Hold key across n ticks, release, and wait until the FSM has taken the release.
  task automatic press(input int n);
    bus.key = 1'b1;
    repeat (3) @(negedge clk);
    repeat (n) do_tick();
    bus.key = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic gap(input int n);
    repeat (n) do_tick();
  endtask

  task automatic glitch();
    bus.key = 1'b1;
    repeat (3) @(negedge clk);
    bus.key = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Full closing gap: valid must appear exactly on the clk after EMIT.
  task automatic close_char(input string tag, input logic [9:0] exp);
    int p0;
    p0 = vpulses;
    gap(GapTicks - 1);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    check_eq({tag, "_early"}, int'(bus.valid), 0);
    @(negedge clk);
    check_eq({tag, "_valid"}, int'(bus.valid), 1);
    check_eq({tag, "_morse"}, int'(bus.morse), int'(exp));
    @(negedge clk);
    check_eq({tag, "_pulses"}, vpulses - p0, 1);
    check_eq({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  initial begin
    int p0;
    bus.key  = 1'b0;
    bus.tick = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_morse", int'(bus.morse), 0);
    check_eq("rst_valid", int'(bus.valid), 0);
    check_eq("rst_busy", int'(bus.busy), 0);
    reset = 1'b0;
    @(negedge clk);

    // R = .-.
    press(1); gap(1); press(3); gap(1); press(1);
    close_char("r", 10'h2E0);

    press(2); close_char("short2", 10'h200);
    press(3); close_char("long3", 10'h300);
    press(300); close_char("sat", 10'h300);

    // Five symbols close the character without waiting for a gap.
    p0 = vpulses;
    for (int i = 0; i < 4; i++) begin
      press(1);
      gap(1);
    end
    bus.key = 1'b1;
    repeat (3) @(negedge clk);
    do_tick();
    bus.key = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("five_early", int'(bus.valid), 0);
    @(negedge clk);
    check_eq("five_valid", int'(bus.valid), 1);
    check_eq("five_morse", int'(bus.morse), 10'h2AA);
    @(negedge clk);
    check_eq("five_busy", int'(bus.busy), 0);
    check_eq("five_pulses", vpulses - p0, 1);

    // Glitch from idle.
    p0 = vpulses;
    bus.key = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("glitch_busy_hi", int'(bus.busy), 1);
    bus.key = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("glitch_busy_lo", int'(bus.busy), 0);
    repeat (4) do_tick();
    check_eq("glitch_pulses", vpulses - p0, 0);
    check_eq("glitch_morse", int'(bus.morse), 10'h2AA);

    // Glitch inside a character adds no symbol.
    press(1); gap(1); glitch(); gap(1); press(3);
    close_char("glitch_in", 10'h2C0);

    // 4-tick gap does not close the character.
    press(1); gap(4); press(3);
    close_char("gap4", 10'h2C0);

    // Reset mid-gap discards the partial word.
    press(1); gap(1); press(3); gap(2);
    p0 = vpulses;
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_morse", int'(bus.morse), 0);
    check_eq("mid_rst_busy", int'(bus.busy), 0);
    reset = 1'b0;
    repeat (10) do_tick();
    check_eq("mid_rst_pulses", vpulses - p0, 0);
    check_eq("mid_rst_hold", int'(bus.morse), 0);
    press(3);
    close_char("after_rst", 10'h300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
